cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter.sv | 142 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two small result FIFOs (ALU, LSB) drained one entry per cycle onto a registered CDB.
// Define CDB_LSB_PRIO_EN for fixed LSB priority; otherwise the arbiter is round-robin.
module cdb_arbiter #(
   parameter int ROB_SIZE_BIT = 4,
   parameter int DATA_W       = 32,
   parameter int FIFO_DEPTH   = 2
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic                    rdy_in,
   input  logic                    rob_clear,
   input  logic                    alu_valid,
   input  logic [ROB_SIZE_BIT-1:0] alu_rob_id,
   input  logic [DATA_W-1:0]       alu_value,
   output logic                    alu_ready,
   input  logic                    lsb_valid,
   input  logic [ROB_SIZE_BIT-1:0] lsb_rob_id,
   input  logic [DATA_W-1:0]       lsb_value,
   output logic                    lsb_ready,
   output logic                    cdb_valid,
   output logic [ROB_SIZE_BIT-1:0] cdb_rob_id,
   output logic [DATA_W-1:0]       cdb_value
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef struct packed {
      logic [ROB_SIZE_BIT-1:0] rob_id;
      logic [DATA_W-1:0]       value;
   } entry_t;

   entry_t           alu_mem [FIFO_DEPTH];
   entry_t           lsb_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] alu_wr_ptr, alu_rd_ptr, lsb_wr_ptr, lsb_rd_ptr;
   logic [CNT_W-1:0] alu_cnt, lsb_cnt;
   logic             alu_ne, lsb_ne;
   logic             grant_alu, grant_lsb;
   logic             advance;
   logic             alu_push, lsb_push, alu_pop, lsb_pop;
   entry_t           head;

   assign alu_ready = (alu_cnt < CNT_FULL);
   assign lsb_ready = (lsb_cnt < CNT_FULL);
   assign alu_ne    = (alu_cnt != '0);
   assign lsb_ne    = (lsb_cnt != '0);

   // A flush or a global stall suppresses every push and pop in the cycle.
   assign advance  = rdy_in && !rob_clear;
   assign alu_push = advance && alu_valid && alu_ready;
   assign lsb_push = advance && lsb_valid && lsb_ready;
   assign alu_pop  = advance && grant_alu;
   assign lsb_pop  = advance && grant_lsb;

`ifdef CDB_LSB_PRIO_EN
   always_comb begin
      grant_alu = 1'b0;
      grant_lsb = 1'b0;
      if (lsb_ne) grant_lsb = 1'b1;
      else        grant_alu = alu_ne;
   end
`else
   typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;
   src_e rr_last;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      grant_alu = 1'b0;
      grant_lsb = 1'b0;
      if (alu_ne && lsb_ne) begin
         grant_alu = (rr_last == SRC_LSB);
         grant_lsb = (rr_last == SRC_ALU);
      end else begin
         grant_alu = alu_ne;
         grant_lsb = lsb_ne;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)                      rr_last <= SRC_LSB;
      else if (advance && grant_alu)      rr_last <= SRC_ALU;
      else if (advance && grant_lsb)      rr_last <= SRC_LSB;
   end
`endif

   assign head = grant_lsb ? lsb_mem[lsb_rd_ptr] : alu_mem[alu_rd_ptr];

   // NOTE: storage is written only behind a valid count, so it needs no reset and stays out of the reset tree.
   always_ff @(posedge clk_in) begin
      if (alu_push) alu_mem[alu_wr_ptr] <= '{rob_id: alu_rob_id, value: alu_value};
      if (lsb_push) lsb_mem[lsb_wr_ptr] <= '{rob_id: lsb_rob_id, value: lsb_value};
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         alu_wr_ptr <= '0;
         alu_rd_ptr <= '0;
         alu_cnt    <= '0;
         lsb_wr_ptr <= '0;
         lsb_rd_ptr <= '0;
         lsb_cnt    <= '0;
      end else if (rdy_in) begin
         if (rob_clear) begin
            alu_wr_ptr <= '0;
            alu_rd_ptr <= '0;
            alu_cnt    <= '0;
            lsb_wr_ptr <= '0;
            lsb_rd_ptr <= '0;
            lsb_cnt    <= '0;
         end else begin
            // Depth is a power of two, so pointers wrap by overflow.
            if (alu_push) alu_wr_ptr <= alu_wr_ptr + PTR_W'(1);
            if (alu_pop)  alu_rd_ptr <= alu_rd_ptr + PTR_W'(1);
            if (lsb_push) lsb_wr_ptr <= lsb_wr_ptr + PTR_W'(1);
            if (lsb_pop)  lsb_rd_ptr <= lsb_rd_ptr + PTR_W'(1);
            alu_cnt <= alu_cnt + CNT_W'(alu_push) - CNT_W'(alu_pop);
            lsb_cnt <= lsb_cnt + CNT_W'(lsb_push) - CNT_W'(lsb_pop);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cdb_valid  <= 1'b0;
         cdb_rob_id <= '0;
         cdb_value  <= '0;
      end else if (rdy_in) begin
         if (rob_clear) begin
            cdb_valid <= 1'b0;
         end else if (grant_alu || grant_lsb) begin
            cdb_valid  <= 1'b1;
            cdb_rob_id <= head.rob_id;
            cdb_value  <= head.value;
         end else begin
            cdb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter, checked against a queue-based reference model.
module tb_cdb_arbiter;

   localparam int RB    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 2;

   logic          clk_in = 1'b0;
   logic          rst_n_in, rdy_in, rob_clear;
   logic          alu_valid, lsb_valid, alu_ready, lsb_ready;
   logic [RB-1:0] alu_rob_id, lsb_rob_id, cdb_rob_id;
   logic [DW-1:0] alu_value, lsb_value, cdb_value;
   logic          cdb_valid;

   cdb_arbiter #(.ROB_SIZE_BIT(RB), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
      .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value), .alu_ready(alu_ready),
      .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value), .lsb_ready(lsb_ready),
      .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [RB-1:0] id;
      logic [DW-1:0] val;
   } res_t;

   res_t          aq[$];
   res_t          lq[$];
   bit            last_lsb;
   logic          exp_valid;
   logic [RB-1:0] exp_id;
   logic [DW-1:0] exp_val;
   int            n_checks = 0;
   int            n_fail   = 0;
   int            pulses;
   int            ready_low;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      aq.delete();
      lq.delete();
      last_lsb  = 1'b1;
      exp_valid = 1'b0;
      exp_id    = '0;
      exp_val   = '0;
   endtask

   task automatic drive(input bit av, input int aid, input int aval,
                        input bit lv, input int lid, input int lval);
      alu_valid  = av;
      alu_rob_id = RB'(aid);
      alu_value  = DW'(aval);
      lsb_valid  = lv;
      lsb_rob_id = RB'(lid);
      lsb_value  = DW'(lval);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst_n_in = 1'b0;
      #1;
      model_reset();
      check("rst_cdb_valid", cdb_valid, 0);
      check("rst_cdb_rob_id", cdb_rob_id, 0);
      check("rst_cdb_value", cdb_value, 0);
      check("rst_alu_ready", alu_ready, 1);
      check("rst_lsb_ready", lsb_ready, 1);
      @(posedge clk_in);
      @(negedge clk_in);
      rst_n_in = 1'b1;
   endtask

   // One clock: predict from the queues, let the edge happen, compare; returns at the next negedge.
   task automatic cycle();
      bit   a_rdy, l_rdy, a_acc, l_acc, take_lsb;
      res_t r;
      a_rdy = (aq.size() < DEPTH);
      l_rdy = (lq.size() < DEPTH);
      check("alu_ready", alu_ready, a_rdy);
      check("lsb_ready", lsb_ready, l_rdy);
      if (!alu_ready || !lsb_ready) ready_low++;
      a_acc = alu_valid && a_rdy;
      l_acc = lsb_valid && l_rdy;
      if (rdy_in) begin
         if (rob_clear) begin
            aq.delete();
            lq.delete();
            exp_valid = 1'b0;
         end else begin
`ifdef CDB_LSB_PRIO_EN
            take_lsb = (lq.size() > 0);
`else
            take_lsb = (lq.size() > 0) && ((aq.size() == 0) || !last_lsb);
`endif
            if (aq.size() > 0 || lq.size() > 0) begin
               if (take_lsb) r = lq.pop_front();
               else          r = aq.pop_front();
               exp_valid = 1'b1;
               exp_id    = r.id;
               exp_val   = r.val;
               last_lsb  = take_lsb;
            end else begin
               exp_valid = 1'b0;
            end
            if (a_acc) aq.push_back('{alu_rob_id, alu_value});
            if (l_acc) lq.push_back('{lsb_rob_id, lsb_value});
         end
      end
      @(posedge clk_in);
      #1;
      check("cdb_valid", cdb_valid, exp_valid);
      check("cdb_rob_id", cdb_rob_id, exp_id);
      check("cdb_value", cdb_value, exp_val);
      if (cdb_valid) pulses++;
      @(negedge clk_in);
   endtask

   initial begin
      int ai, li;
      bit a_go, l_go;
      rst_n_in  = 1'b1;
      rdy_in    = 1'b1;
      rob_clear = 1'b0;
      idle();
      #2;
      do_reset();

      // Single ALU result: one pulse, two cycles after valid.
      pulses = 0;
      drive(1, 3, 'h55, 0, 0, 0);
      cycle();
      idle();
      repeat (4) cycle();
      check("single_pulses", pulses, 1);

      // Tie after reset goes to ALU; after an ALU-only grant the next tie goes to LSB.
      do_reset();
      drive(1, 1, 'hA, 1, 2, 'hB);
      cycle();
      idle();
      repeat (3) cycle();
      drive(1, 5, 'h77, 0, 0, 0);
      cycle();
      idle();
      repeat (2) cycle();
      drive(1, 1, 'hA, 1, 2, 'hB);
      cycle();
      idle();
      repeat (3) cycle();

      // Backpressure: both sources offer ids 0..7, holding while not ready.
      pulses    = 0;
      ready_low = 0;
      ai = 0;
      li = 0;
      for (int c = 0; c < 40; c++) begin
         drive(ai < 8, ai, 'h100 + ai, li < 8, li, 'h200 + li);
         a_go = alu_valid && (aq.size() < DEPTH);
         l_go = lsb_valid && (lq.size() < DEPTH);
         cycle();
         if (a_go) ai++;
         if (l_go) li++;
      end
      idle();
      check("bp_pulses", pulses, 16);
      check("bp_ready_dropped", ready_low > 0, 1);

      // Flush with entries queued and pushes presented in the flush cycle.
      drive(1, 6, 'h66, 1, 7, 'h77);
      cycle();
      drive(1, 8, 'h88, 0, 0, 0);
      cycle();
      rob_clear = 1'b1;
      drive(1, 9, 'h99, 1, 10, 'hAA);
      cycle();
      rob_clear = 1'b0;
      idle();
      pulses = 0;
      repeat (4) cycle();
      check("flush_pulses", pulses, 0);

      // Global stall holds all state including cdb_valid.
      drive(1, 11, 'hB1, 1, 12, 'hC2);
      cycle();
      cycle();
      rdy_in = 1'b0;
      repeat (3) cycle();
      rdy_in = 1'b1;
      idle();
      repeat (4) cycle();

      // Random traffic with stalls, flushes and one mid-run reset.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom,
               $urandom_range(0, 1), $urandom_range(0, 15), $urandom);
         rdy_in    = ($urandom_range(0, 9) != 0);
         rob_clear = ($urandom_range(0, 29) == 0);
         if (i == 200) begin
            do_reset();
         end else begin
            cycle();
         end
      end
      rdy_in    = 1'b1;
      rob_clear = 1'b0;
      idle();
      repeat (4) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
